// File: rtl/counter_sequencer.sv
// Programmable interval timer sequencer: start/pause/stop control around a
// WIDTH-bit up-counter with a terminal tick, a sticky done state and optional auto-reload.
module counter_sequencer #(
    parameter int unsigned            WIDTH         = 4,
    parameter logic [WIDTH-1:0]       DEFAULT_LIMIT = 4'd9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_reload,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             reload_q, reload_d;

    // stop wins over start everywhere, so decode the resume request once.
    logic go;
    assign go = start & ~stop;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            tick_q   <= 1'b0;
            limit_q  <= DEFAULT_LIMIT;
            reload_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            tick_q   <= tick_d;
            limit_q  <= limit_d;
            reload_q <= reload_d;
        end
    end

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tick_d   = 1'b0;
        limit_d  = limit_q;
        reload_d = reload_q;

        unique case (state_q)
            IDLE: begin
                count_d = '0;
                if (cfg_we) begin
                    limit_d  = cfg_limit;
                    reload_d = cfg_reload;
                end
                if (go) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                // Pausing takes precedence over the terminal wrap.
                if (stop) begin
                    state_d = HOLD;
                end else if (count_q == limit_q) begin
                    count_d = '0;
                    tick_d  = 1'b1;
                    state_d = reload_q ? RUN : DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (start) begin
                    state_d = RUN;
                end
            end

            DONE: begin
                count_d = '0;
                if (cfg_we) begin
                    limit_d  = cfg_limit;
                    reload_d = cfg_reload;
                end
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign done  = (state_q == DONE);
    assign busy  = (state_q == RUN) || (state_q == HOLD);
    assign state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: directed scenarios with literal
// expectations plus a cycle-by-cycle comparison against a behavioural timer model.
module tb_counter_sequencer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic             stop;
    logic             cfg_we;
    logic [WIDTH-1:0] cfg_limit;
    logic             cfg_reload;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             done;
    logic             busy;
    logic [1:0]       state;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    counter_sequencer #(.WIDTH(WIDTH), .DEFAULT_LIMIT(4'd9)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .cfg_we     (cfg_we),
        .cfg_limit  (cfg_limit),
        .cfg_reload (cfg_reload),
        .count      (count),
        .tick       (tick),
        .done       (done),
        .busy       (busy),
        .state      (state)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a timer that is either idle, finished, counting or
    // paused, with a period of limit+1 cycles per terminal tick.
    int m_count    = 0;
    int m_limit    = 9;
    bit m_reload   = 0;
    bit m_active   = 0;
    bit m_paused   = 0;
    bit m_finished = 0;
    bit m_tick     = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_count = 0; m_limit = 9; m_reload = 0;
            m_active = 0; m_paused = 0; m_finished = 0; m_tick = 0;
        end else begin
            m_tick = 0;
            if (cfg_we && !m_active) begin
                m_limit  = int'(cfg_limit);
                m_reload = cfg_reload;
            end
            if (m_active && !m_paused) begin
                if (stop) m_paused = 1;
                else if (m_count == m_limit) begin
                    m_count = 0;
                    m_tick  = 1;
                    if (!m_reload) begin
                        m_active   = 0;
                        m_finished = 1;
                    end
                end else m_count = m_count + 1;
            end else if (m_paused) begin
                if (stop) begin
                    m_active = 0; m_paused = 0; m_count = 0;
                end else if (start) m_paused = 0;
            end else begin
                m_count = 0;
                if (stop) m_finished = 0;
                else if (start) begin
                    m_active = 1; m_finished = 0;
                end
            end
        end
    end

    function automatic int model_state();
        if (m_finished) return 3;
        if (m_paused)   return 2;
        if (m_active)   return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("mdl_count", 32'(count), 32'(m_count));
            check("mdl_tick",  32'(tick),  32'(m_tick));
            check("mdl_done",  32'(done),  32'(m_finished));
            check("mdl_busy",  32'(busy),  32'(m_active));
            check("mdl_state", 32'(state), 32'(model_state()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic configure(input int lim, input bit rel);
        cfg_we = 1; cfg_limit = WIDTH'(lim); cfg_reload = rel;
        step();
        cfg_we = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic pulse_stop();
        stop = 1;
        step();
        stop = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; start = 0; stop = 0; cfg_we = 0; cfg_limit = '0; cfg_reload = 0;
        #15;
        reset = 0;
        cmp_en = 1;
        check("rst_state", 32'(state), 0);
        check("rst_count", 32'(count), 0);
        check("rst_flags", {29'd0, tick, done, busy}, 0);

        // Default one-shot with limit 9.
        pulse_start();
        check("t1_e0_count", 32'(count), 0);
        check("t1_e0_state", 32'(state), 1);
        for (int i = 1; i <= 9; i++) begin
            step();
            check("t1_count", 32'(count), 32'(i));
        end
        step();
        check("t1_wrap_count", 32'(count), 0);
        check("t1_wrap_tick", 32'(tick), 1);
        check("t1_wrap_done", 32'(done), 1);
        check("t1_wrap_state", 32'(state), 3);
        step();
        check("t1_tick_low", 32'(tick), 0);
        pulse_stop();
        check("t1_to_idle", 32'(state), 0);

        // Auto-reload with limit 2.
        configure(2, 1);
        pulse_start();
        check("t2_e0_count", 32'(count), 0);
        for (int i = 1; i <= 6; i++) begin
            step();
            check("t2_count", 32'(count), 32'(i % 3));
            check("t2_tick", 32'(tick), (i % 3 == 0) ? 1 : 0);
            check("t2_busy_done", {30'd0, busy, done}, 2);
        end
        pulse_stop();
        pulse_stop();
        check("t2_abort_state", 32'(state), 0);

        // Pause and resume with limit 5 one-shot.
        configure(5, 0);
        pulse_start();
        steps(3);
        check("t3_pre_stop", 32'(count), 3);
        pulse_stop();
        for (int i = 0; i < 4; i++) begin
            check("t3_hold_state", 32'(state), 2);
            check("t3_hold_count", 32'(count), 3);
            step();
        end
        pulse_start();
        check("t3_resume_count", 32'(count), 3);
        step();
        check("t3_count4", 32'(count), 4);
        step();
        check("t3_count5", 32'(count), 5);
        step();
        check("t3_wrap", {27'd0, count, tick}, 1);
        check("t3_done_state", 32'(state), 3);

        // Abort from HOLD, stop over wrap, and stop-over-start priority.
        pulse_start();
        steps(3);
        pulse_stop();
        pulse_stop();
        check("t4_abort_state", 32'(state), 0);
        check("t4_abort_count", 32'(count), 0);
        check("t4_abort_tick", 32'(tick), 0);
        pulse_start();
        steps(5);
        check("t4_at_limit", 32'(count), 5);
        pulse_stop();
        check("t4_stop_wins_state", 32'(state), 2);
        check("t4_stop_wins_tick", {27'd0, count, tick}, 10);
        pulse_stop();
        start = 1; stop = 1;
        step();
        start = 0; stop = 0;
        check("t4_both_idle", 32'(state), 0);

        // Config lockout during RUN.
        configure(7, 0);
        pulse_start();
        steps(2);
        cfg_we = 1; cfg_limit = 4'd1; cfg_reload = 0;
        step();
        cfg_we = 0;
        check("t5_no_mid_write", 32'(count), 3);
        steps(4);
        check("t5_count7", 32'(count), 7);
        step();
        check("t5_tick", 32'(tick), 1);
        check("t5_done", 32'(state), 3);
        configure(1, 0);
        pulse_start();
        step();
        check("t5_new_count1", 32'(count), 1);
        step();
        check("t5_new_tick", 32'(tick), 1);

        // Async reset mid-run; limit must return to 9.
        configure(12, 0);
        pulse_start();
        steps(4);
        check("t6_pre_reset", 32'(count), 4);
        #3;
        reset = 1;
        #1;
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_state", 32'(state), 0);
        check("t6_rst_busy_tick", {30'd0, busy, tick}, 0);
        #2;
        reset = 0;
        pulse_start();
        steps(9);
        check("t6_count9", 32'(count), 9);
        step();
        check("t6_default_tick", 32'(tick), 1);
        check("t6_default_done", 32'(state), 3);
        step();

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Control block that sequences a WIDTH-bit up-counter as a programmable interval timer. It provides start/pause/stop control, a configurable terminal value, and one-shot or auto-reload modes. It emits a one-cycle terminal tick and a sticky done flag. It sits beside the ripple counter datapath and gives the system a sequenced counting resource in place of a free-running one.

Parameters:
WIDTH, 4, counter and limit width in bits
DEFAULT_LIMIT, 4'd9, terminal value loaded at reset (WIDTH bits)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset; clears all state immediately
start  input  1  level sampled each edge; begin or resume counting
stop  input  1  level sampled each edge; pause, or abort when already paused
cfg_we  input  1  configuration write strobe
cfg_limit  input  WIDTH  terminal count value, captured when cfg_we is accepted
cfg_reload  input  1  1 = auto-reload, 0 = one-shot; captured with cfg_limit
count  output  WIDTH  current count value (registered)
tick  output  1  one-cycle pulse on each terminal-count wrap (registered)
done  output  1  high while in DONE state
busy  output  1  high while in RUN or HOLD
state  output  2  FSM state encoding: IDLE=0, RUN=1, HOLD=2, DONE=3

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high. All outputs are registered or decoded only from registered state.
- Reset values: state=IDLE, count=0, tick=0, done=0, busy=0, limit_reg=DEFAULT_LIMIT, reload_reg=0.
- Config:
  - cfg_we is accepted only in IDLE or DONE; limit_reg and reload_reg update at that edge.
  - cfg_we is ignored in RUN or HOLD; the active limit never changes mid-run.
- Control priority: stop beats start when both are high in the same cycle.
- IDLE:
  - count held at 0.
  - start (and no stop) -> RUN; count stays 0 at that edge.
- RUN:
  - Each edge: if count != limit_reg, count = count+1.
  - If count == limit_reg: count -> 0, tick = 1 for the next cycle, and the state goes to RUN if reload_reg=1, otherwise to DONE.
  - stop -> HOLD with count frozen; this takes priority over the terminal wrap in the same cycle.
- HOLD:
  - count frozen.
  - start (no stop) -> RUN, and counting resumes from the frozen value.
  - stop -> IDLE with count cleared to 0.
- DONE:
  - done=1, count=0.
  - start (no stop) -> RUN.
  - stop -> IDLE.
- Period: limit_reg+1 cycles from entering RUN with count=0 to the tick.
  - limit_reg=0 gives a tick every cycle in reload mode, and one tick then DONE in one-shot mode.
- Widths: count never exceeds limit_reg; there is no wrap beyond 2^WIDTH-1. limit=2^WIDTH-1 gives the full 2^WIDTH-cycle period.
- tick is low in every cycle except the single cycle following a terminal wrap. It is never asserted in HOLD, IDLE or on reset.
- Reset mid-operation: all state returns to reset values asynchronously, including limit_reg. A tick in flight is dropped.
- busy = (state==RUN) or (state==HOLD).

Test Plan:
1. Reset and default one-shot: reset high 15 ns then low; start for one cycle (edge E0). Required: count 0 after E0, then 1..9 after E1..E9; count=0, tick=1, done=1, state=3 after E10; tick=0 after E11.
2. Auto-reload: in IDLE, cfg_we with cfg_limit=2, cfg_reload=1; then start. Required: count sequence 0,1,2,0,1,2; tick high one cycle every 3 cycles; busy stays 1; done stays 0.
3. Pause and resume: limit=5 one-shot, start; stop when count=3. Required: state=2, count holds 3 for 4 cycles. Then start: count 4,5,0 with the tick after count 5.
4. Abort and priority: limit=5 one-shot, start, then stop when count=3, then stop again while in HOLD. Required: state=0, count=0, no tick. Separately, start and stop both high in IDLE -> state stays 0.
5. Config lockout: while in RUN with limit=7, pulse cfg_we with cfg_limit=1. Required: the run still ticks after count 7. After DONE, the same write is accepted and the next run ticks after count 1.
6. Async reset mid-run: assert reset between clock edges at count=4. Required: count=0, state=0, busy=0, tick=0 immediately without waiting for a clock edge; limit returns to 9.
